// File: rtl/func_issuer.sv
// func_issuer: instruction issuer for the processor's external instruction port.
//
// Host-side 25-bit instruction words are buffered in a circular FIFO. Each word is
// popped into the registered `func` output and announced with a one-cycle `new_func`
// strobe. The next word is issued only after the processor's `cur_state` has left
// IDLE_STATE and then come back to it.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   push, push_func  enqueue request and instruction word
//   full, empty      FIFO status (derived from the registered occupancy)
//   count            FIFO occupancy, 0..DEPTH
//   overflow         sticky: a push was dropped because the FIFO was full
//   cur_state        processor control-unit state, same clock domain, no synchronizer
//   func, new_func   instruction presented to the processor, one-cycle issue strobe
//   busy             an instruction is in flight (FSM not in IDLE)
//   timeout_err      sticky watchdog flag
//
// Optional feature: define FUNC_ISSUER_TIMEOUT_EN to add a watchdog. It forces the FSM
// back to IDLE after TIMEOUT cycles in the wait states and sets timeout_err. Without
// the macro, the FSM waits indefinitely and timeout_err is tied to 0.

module func_issuer #(
  parameter int                 DEPTH      = 8,
  parameter int                 FUNC_W     = 25,
  parameter int                 STATE_W    = 5,
  parameter logic [STATE_W-1:0] IDLE_STATE = '0,
  parameter int                 TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [FUNC_W-1:0]        push_func,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic [STATE_W-1:0]       cur_state,
  output logic [FUNC_W-1:0]        func,
  output logic                     new_func,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("func_issuer: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("func_issuer: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [FUNC_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop;
  logic              push_ok;

  // A word leaves the FIFO only on the IDLE->ISSUE transition. A push into a full
  // FIFO is still accepted when that same cycle frees a slot.
  assign pop     = (state == IDLE) && !empty;
  assign push_ok = push && (!full || pop);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

`ifdef FUNC_ISSUER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_hit;

  // Watchdog counter. It is cleared while in ISSUE, so it holds 0 on entry to
  // WAIT_START. It then holds k-1 during the k-th wait cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)
        wd_cnt <= '0;
      else if (state == WAIT_START || state == WAIT_DONE)
        wd_cnt <= wd_cnt + 1'b1;
      if (timeout_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // Next-state logic. WAIT_START keeps the cycles in which the processor still
  // reports idle right after the strobe from being taken as completion.
  always_comb begin
    next_state = state;
`ifdef FUNC_ISSUER_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state)
      IDLE:       if (!empty) next_state = ISSUE;
      ISSUE:      next_state = WAIT_START;
      WAIT_START: if (cur_state != IDLE_STATE) next_state = WAIT_DONE;
      WAIT_DONE:  if (cur_state == IDLE_STATE) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
`ifdef FUNC_ISSUER_TIMEOUT_EN
    // On the TIMEOUT-th wait cycle, abandon the stuck instruction.
    if ((state == WAIT_START || state == WAIT_DONE) && wd_cnt == CNT_W'(TIMEOUT - 1)) begin
      next_state  = IDLE;
      timeout_hit = 1'b1;
    end
`endif
  end

  // Output logic.
  always_comb begin
    new_func = (state == ISSUE);
    busy     = (state != IDLE);
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
  end

  // FIFO storage. It has no reset: the contents are meaningless once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr] <= push_func;
  end

  // FIFO pointers, occupancy, sticky overflow, and the func register.
  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      func     <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        func   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (pop && !push_ok)
        count <= count - 1'b1;
      if (push && !push_ok)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_func_issuer.sv
// Testbench for func_issuer.
//
// A queue-based model predicts every output on every cycle, and one compare process
// checks the DUT against it. A small processor model drives cur_state after each
// strobe. Directed scenarios are followed by a randomized phase.

module tb_func_issuer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic        push;
  logic [24:0] push_func;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic [4:0]  cur_state;
  logic [24:0] func;
  logic        new_func;
  logic        busy;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  func_issuer #(
    .DEPTH(DEPTH), .FUNC_W(25), .STATE_W(5), .IDLE_STATE(5'd0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .push_func(push_func),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .cur_state(cur_state), .func(func), .new_func(new_func), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives the inputs for one full cycle. Returns at the following falling edge,
  // when the outputs reflect the rising edge that consumed these inputs.
  task automatic applyStimulus(input bit p, input logic [24:0] w, input bit r);
    push      = p;
    push_func = w;
    rst       = r;
    @(negedge clk);
  endtask

  // Reference model. It holds the queue of pending words and one in-flight
  // instruction. That instruction first needs a non-idle cur_state and then an idle
  // one, both sampled after its strobe cycle.
  logic [24:0] mq[$];
  logic [24:0] m_func;
  bit          m_inflight, m_strobe, m_left, m_ovf, m_terr, m_valid;
  int          m_waited;

  initial m_valid = 0;

  always @(posedge clk) begin
    bit popping;
    if (rst) begin
      mq.delete();
      m_func = '0; m_inflight = 0; m_strobe = 0; m_left = 0;
      m_ovf = 0; m_terr = 0; m_waited = 0; m_valid = 1;
    end else if (m_valid) begin
      popping = !m_inflight && mq.size() > 0;
      if (m_inflight) begin
        if (m_strobe) begin
          m_strobe = 0; m_left = 0; m_waited = 0;
        end else begin
          m_waited++;
          if (!m_left) m_left = (cur_state != 5'd0);
          else if (cur_state == 5'd0) m_inflight = 0;
`ifdef FUNC_ISSUER_TIMEOUT_EN
          if (m_waited == TIMEOUT) begin
            m_inflight = 0;
            m_terr = 1;
          end
`endif
        end
      end
      if (popping) begin
        m_func = mq.pop_front();
        m_inflight = 1;
        m_strobe = 1;
      end
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(push_func);
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_busy",     busy,        m_inflight);
      checkOutput("model_new_func", new_func,    m_strobe);
      checkOutput("model_func",     func,        m_func);
      checkOutput("model_count",    count,       mq.size());
      checkOutput("model_empty",    empty,       mq.size() == 0);
      checkOutput("model_full",     full,        mq.size() == DEPTH);
      checkOutput("model_overflow", overflow,    m_ovf);
      checkOutput("model_timeout",  timeout_err, m_terr);
    end
  end

  // Processor model. A strobe loads a plan: plan_idle idle cycles, then plan_run
  // non-idle cycles, then idle. The plan starts at the next falling edge.
  bit         proc_auto;
  bit         plan_rand;
  int         plan_idle;
  int         plan_run;
  logic [4:0] plan[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!proc_auto) begin
        plan.delete();
      end else begin
        if (plan.size() > 0) cur_state = plan.pop_front();
        if (new_func) begin
          int n_idle;
          int n_run;
          n_idle = plan_rand ? int'($urandom_range(0, 3)) : plan_idle;
          n_run  = plan_rand ? int'($urandom_range(1, 4)) : plan_run;
          plan.delete();
          for (int i = 0; i < n_idle; i++) plan.push_back(5'd0);
          for (int i = 0; i < n_run; i++)
            plan.push_back(plan_rand ? 5'($urandom_range(1, 31)) : 5'(i + 1));
          plan.push_back(5'd0);
        end
      end
    end
  end

  initial begin
    push = 0; push_func = '0; rst = 1; cur_state = '0;
    proc_auto = 0; plan_rand = 0; plan_idle = 0; plan_run = 2;

    // Reset values.
    applyStimulus(0, '0, 1);
    applyStimulus(0, '0, 1);
    checkOutput("reset_busy",  busy,  0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_func",  func,  0);

    // Single word: the strobe comes 2 edges after the push; processor runs 1 -> 2 -> 0.
    proc_auto = 1;
    applyStimulus(1, 25'h0000123, 0);
    applyStimulus(0, '0, 0);
    checkOutput("single_strobe", new_func, 1);
    checkOutput("single_func",   func,     25'h0000123);
    applyStimulus(0, '0, 0);
    checkOutput("single_strobe_width", new_func, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, '0, 0);
    checkOutput("single_done_busy",  busy,  0);
    checkOutput("single_done_empty", empty, 1);

    // Three back-to-back words with a 3-cycle processor.
    plan_run = 3;
    applyStimulus(1, 25'h1, 0);
    applyStimulus(1, 25'h2, 0);
    applyStimulus(1, 25'h3, 0);
    for (int i = 0; i < 30; i++) applyStimulus(0, '0, 0);

    // cur_state stays idle for 10 cycles after the strobe: no completion yet.
    proc_auto = 0;
    cur_state = 5'd0;
    applyStimulus(1, 25'h44, 0);
    applyStimulus(1, 25'h55, 0);
    checkOutput("hold_idle_strobe", new_func, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, '0, 0);
    checkOutput("hold_idle_busy", busy, 1);
    cur_state = 5'd1;
    applyStimulus(0, '0, 0);
    cur_state = 5'd0;
    for (int i = 0; i < 8; i++) applyStimulus(0, '0, 0);
    checkOutput("hold_idle_second_func", func, 25'h55);

    // Processor stuck non-idle: one pop, then the FIFO refills and overflows.
    // The pop frees one slot, so 10 pushes are needed before one is dropped.
    applyStimulus(0, '0, 1);
    cur_state = 5'd1;
    for (int i = 0; i < 10; i++) applyStimulus(1, 25'(32'h100 + i), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0);
    checkOutput("ovf_flag",  overflow, 1);
    checkOutput("ovf_count", count,    8);
    checkOutput("ovf_full",  full,     1);

    // Reset during WAIT_DONE with 4 words queued; the push in the reset cycle is ignored.
    applyStimulus(0, '0, 1);
    cur_state = 5'd1;
    for (int i = 0; i < 5; i++) applyStimulus(1, 25'(32'h200 + i), 0);
    applyStimulus(0, '0, 0);
    checkOutput("midrst_queued", count, 4);
    applyStimulus(1, 25'h1ff, 1);
    checkOutput("midrst_busy",     busy,     0);
    checkOutput("midrst_count",    count,    0);
    checkOutput("midrst_func",     func,     0);
    checkOutput("midrst_new_func", new_func, 0);
    cur_state = 5'd0;
    for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0);
    checkOutput("midrst_no_strobe", busy, 0);

`ifdef FUNC_ISSUER_TIMEOUT_EN
    // Stuck processor: the watchdog drops the instruction and issues the next one.
    applyStimulus(0, '0, 1);
    cur_state = 5'd3;
    applyStimulus(1, 25'h0aa, 0);
    applyStimulus(1, 25'h0bb, 0);
    for (int i = 0; i < TIMEOUT + 4; i++) applyStimulus(0, '0, 0);
    checkOutput("wd_flag", timeout_err, 1);
    checkOutput("wd_next_func", func, 25'h0bb);
    cur_state = 5'd0;
`endif

    // Randomized traffic with a randomized processor and rare resets.
    applyStimulus(0, '0, 1);
    cur_state = 5'd0;
    proc_auto = 1;
    plan_rand = 1;
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 99) < 40, 25'($urandom), $urandom_range(0, 499) == 0);
    for (int i = 0; i < 60; i++) applyStimulus(0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
